vending_controller_param: RTL and testbench

- Parametrised multi-product vending controller; successor to the single-price 2-bit-coin FSM.
- Accumulates credit from three coin denominations and validates product selection against a per-product price table and stock flags.
- Hands the product to the dispenser over a valid/ready handshake.
- Returns change, or a cancel refund, one coin per handshake, largest denomination first.
- Sits between the coin acceptor / keypad front end and the dispenser / coin-hopper drivers.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/change_dispenser.sv | 54 +++++
 rtl/vending_controller_param.sv | 131 +++++++++++++
 tb/tb_vending_controller_param.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and coin helpers for the parametrised vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_e;

    localparam logic [1:0] COIN_1   = 2'd0;
    localparam logic [1:0] COIN_2   = 2'd1;
    localparam logic [1:0] COIN_5   = 2'd2;
    localparam logic [1:0] COIN_BAD = 2'd3;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 3'd1;
            COIN_2:  return 3'd2;
            COIN_5:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // Greedy denomination choice; never returns a coin worth more than amount (for amount >= 1).
    function automatic logic [1:0] largest_coin(input logic [31:0] amount);
        if (amount >= 32'd5) return COIN_5;
        if (amount >= 32'd2) return COIN_2;
        return COIN_1;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Returns an amount as a sequence of coins over a valid/ready handshake, largest first.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CREDIT_W-1:0] amount,
    input  logic                change_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                done
);

    logic [CREDIT_W-1:0] remaining_q, remaining_d, value;
    logic                valid_q, valid_d;
    logic [1:0]          coin_q, coin_d;

    always_comb begin
        value       = CREDIT_W'(coin_value(coin_q));
        remaining_d = remaining_q;
        valid_d     = valid_q;
        coin_d      = coin_q;
        done        = valid_q && change_ready && (remaining_q == value);
        if (start) begin
            remaining_d = amount;
            valid_d     = (amount != '0);
            coin_d      = largest_coin(32'(amount));
        end else if (valid_q && change_ready) begin
            // Next coin is presented straight after an accept, no idle gap.
            remaining_d = remaining_q - value;
            valid_d     = !done;
            coin_d      = largest_coin(32'(remaining_d));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            valid_q     <= 1'b0;
            coin_q      <= COIN_1;
        end else begin
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            coin_q      <= coin_d;
        end
    end

    assign change_valid = valid_q;
    assign change_coin  = coin_q;

endmodule

// File: rtl/vending_controller_param.sv
// Multi-product vending controller: credit accumulation, priced selection, dispense and change.
module vending_controller_param
    import vending_pkg::*;
#(
    parameter int                                NUM_PRODUCTS = 4,
    parameter int                                CREDIT_W     = 8,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES       = {8'd15, 8'd10, 8'd7, 8'd5},
    parameter int                                MAX_CREDIT   = 50,
    localparam int                               SEL_W        = $clog2(NUM_PRODUCTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coin_valid,
    input  logic [1:0]              coin_type,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    cancel,
    input  logic [NUM_PRODUCTS-1:0] stock_empty,
    output logic                    vend_valid,
    output logic [SEL_W-1:0]        vend_id,
    input  logic                    vend_ready,
    output logic                    change_valid,
    output logic [1:0]              change_coin,
    input  logic                    change_ready,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    coin_reject,
    output logic                    sel_reject,
    output logic                    busy
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, price_sel;
    logic                vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]    vend_id_q, vend_id_d;
    logic                coin_reject_q, coin_reject_d, sel_reject_q, sel_reject_d, busy_q, busy_d;
    logic                stock_sel, front, do_cancel, do_sel, do_coin;
    logic                vend_done, chg_start, chg_done, chg_accept;
    logic [CREDIT_W:0]   coin_sum;

    // Resolve the single front-end action that wins this cycle (cancel > select > coin).
    always_comb begin
        price_sel = '0;
        stock_sel = 1'b1;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (int'(sel) == i) begin
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                stock_sel = stock_empty[i];
            end
        end
        front      = (state_q == IDLE) || (state_q == CREDIT);
        coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_type));
        do_cancel  = (state_q == CREDIT) && cancel;
        do_sel     = front && !do_cancel && sel_valid && !stock_sel && (credit_q >= price_sel);
        do_coin    = front && !do_cancel && !sel_valid && coin_valid && (coin_type != COIN_BAD)
                     && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
        vend_done  = (state_q == VEND) && vend_ready;
        chg_start  = do_cancel || (vend_done && (credit_q != '0));
        chg_accept = change_valid && change_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CREDIT: begin
                if (do_cancel)    state_d = CHANGE;
                else if (do_sel)  state_d = VEND;
                else if (do_coin) state_d = CREDIT;
            end
            VEND:    if (vend_done) state_d = (credit_q != '0) ? CHANGE : IDLE;
            CHANGE:  if (chg_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        if (do_sel)
            credit_d = credit_q - price_sel;
        else if (do_coin)
            credit_d = coin_sum[CREDIT_W-1:0];
        else if ((state_q == CHANGE) && chg_accept)
            credit_d = credit_q - CREDIT_W'(coin_value(change_coin));
        vend_valid_d  = do_sel || (vend_valid_q && !vend_ready);
        vend_id_d     = do_sel ? sel : vend_id_q;
        coin_reject_d = coin_valid && !do_coin;
        sel_reject_d  = sel_valid && !do_sel && !do_cancel;
        busy_d        = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q      <= '0;
            vend_valid_q  <= 1'b0;
            vend_id_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_reject_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            credit_q      <= credit_d;
            vend_valid_q  <= vend_valid_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            sel_reject_q  <= sel_reject_d;
            busy_q        <= busy_d;
        end
    end

    change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
        .clk          (clk),
        .rst          (rst),
        .start        (chg_start),
        .amount       (credit_q),
        .change_ready (change_ready),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .done         (chg_done)
    );

    assign credit      = credit_q;
    assign vend_valid  = vend_valid_q;
    assign vend_id     = vend_id_q;
    assign coin_reject = coin_reject_q;
    assign sel_reject  = sel_reject_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vending_controller_param.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_vending_controller_param;

    localparam logic [1:0] C1 = 2'd0, C2 = 2'd1, C5 = 2'd2, CB = 2'd3;

    logic       clk = 1'b0;
    logic       rst, coin_valid, sel_valid, cancel, vend_ready, change_ready;
    logic [1:0] coin_type, sel, vend_id, change_coin;
    logic [3:0] stock_empty;
    logic       vend_valid, change_valid, coin_reject, sel_reject, busy;
    logic [7:0] credit;

    int checks = 0;
    int failures = 0;

    // Product i's price sits at bits [i*8 +: 8] of the default table, so product 0 costs 5.
    int price[4] = '{5, 7, 10, 15};

    // Model: mode 0 idle, 1 holding credit, 2 vending, 3 returning change.
    int m_mode, m_credit, m_vid, m_coin;
    bit m_vv, m_cv, m_crej, m_srej;

    always #5 clk = ~clk;

    vending_controller_param dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .stock_empty(stock_empty),
        .vend_valid(vend_valid), .vend_id(vend_id), .vend_ready(vend_ready),
        .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
        .credit(credit), .coin_reject(coin_reject), .sel_reject(sel_reject), .busy(busy)
    );

    function automatic int cval(input int c);
        return (c == 0) ? 1 : (c == 1) ? 2 : (c == 2) ? 5 : 0;
    endfunction

    function automatic int lcoin(input int amt);
        return (amt >= 5) ? 2 : (amt >= 2) ? 1 : 0;
    endfunction

    task automatic model_update();
        bit crej = 1'b0;
        bit srej = 1'b0;
        if (rst) begin
            m_mode = 0; m_credit = 0; m_vid = 0; m_coin = 0;
            m_vv = 0; m_cv = 0; m_crej = 0; m_srej = 0;
            return;
        end
        if (m_mode <= 1) begin
            if (cancel && m_mode == 1) begin
                m_mode = 3; m_cv = 1; m_coin = lcoin(m_credit); crej = coin_valid;
            end else if (sel_valid) begin
                if (!stock_empty[sel] && m_credit >= price[sel]) begin
                    m_credit -= price[sel]; m_vv = 1; m_vid = int'(sel); m_mode = 2;
                end else srej = 1'b1;
                crej = coin_valid;
            end else if (coin_valid) begin
                if (coin_type == CB || m_credit + cval(coin_type) > 50) crej = 1'b1;
                else begin m_credit += cval(coin_type); m_mode = 1; end
            end
        end else begin
            crej = coin_valid;
            srej = sel_valid;
            if (m_mode == 2 && vend_ready) begin
                m_vv = 0;
                if (m_credit > 0) begin m_mode = 3; m_cv = 1; m_coin = lcoin(m_credit); end
                else m_mode = 0;
            end else if (m_mode == 3 && change_ready) begin
                m_credit -= cval(m_coin);
                if (m_credit == 0) begin m_cv = 0; m_coin = 0; m_mode = 0; end
                else m_coin = lcoin(m_credit);
            end
        end
        m_crej = crej;
        m_srej = srej;
    endtask

    // One clock: update model from pre-edge inputs, advance, then drop strobes.
    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        coin_valid = 0; sel_valid = 0; cancel = 0;
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1; coin_type = code;
        tick();
    endtask

    task automatic do_reset();
        rst = 1; vend_ready = 0; change_ready = 0; stock_empty = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({credit, vend_valid, vend_id, change_valid, change_coin, coin_reject, sel_reject, busy} !== 17'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {credit, vend_valid, vend_id, change_valid, change_coin, coin_reject, sel_reject, busy}); end
    endtask

    task automatic test_exact_vend();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            coin(C5);
            checks++; if (credit !== 8'(5 * (k + 1))) begin failures++; $display("FAIL exact_credit%0d got=%0d exp=%0d", k, credit, 5 * (k + 1)); end
        end
        vend_ready = 1; sel_valid = 1; sel = 2'd3;
        tick();
        checks++; if ({vend_valid, vend_id, credit, busy} !== {1'b1, 2'd3, 8'd0, 1'b1}) begin
            failures++; $display("FAIL exact_vend got vv=%b id=%0d cr=%0d busy=%b exp 1/3/0/1", vend_valid, vend_id, credit, busy); end
        tick();
        checks++; if ({vend_valid, change_valid, busy, credit} !== 11'd0) begin
            failures++; $display("FAIL exact_idle got vv=%b cv=%b busy=%b cr=%0d exp all 0", vend_valid, change_valid, busy, credit); end
        tick();
        checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL exact_nochange got=%b exp=0", change_valid); end
    endtask

    task automatic test_vend_with_change();
        do_reset();
        coin(C5); coin(C5);
        sel_valid = 1; sel = 2'd1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if ({vend_valid, vend_id, credit} !== {1'b1, 2'd1, 8'd3}) begin
                failures++; $display("FAIL vend_hold%0d got vv=%b id=%0d cr=%0d exp 1/1/3", k, vend_valid, vend_id, credit); end
            if (k == 2) vend_ready = 1;
            tick();
        end
        vend_ready = 0;
        checks++; if ({vend_valid, change_valid, change_coin, credit} !== {1'b0, 1'b1, C2, 8'd3}) begin
            failures++; $display("FAIL change_first got vv=%b cv=%b coin=%0d cr=%0d exp 0/1/1/3", vend_valid, change_valid, change_coin, credit); end
        change_ready = 1;
        tick();
        checks++; if ({change_valid, change_coin, credit} !== {1'b1, C1, 8'd1}) begin
            failures++; $display("FAIL change_second got cv=%b coin=%0d cr=%0d exp 1/0/1", change_valid, change_coin, credit); end
        tick();
        checks++; if ({change_valid, busy, credit} !== 10'd0) begin
            failures++; $display("FAIL change_done got cv=%b busy=%b cr=%0d exp 0/0/0", change_valid, busy, credit); end
        change_ready = 0;
    endtask

    task automatic test_stock_and_cancel();
        do_reset();
        coin(C2); coin(C1);
        stock_empty = 4'b1000; sel_valid = 1; sel = 2'd3;
        tick();
        checks++; if ({sel_reject, credit, vend_valid} !== {1'b1, 8'd3, 1'b0}) begin
            failures++; $display("FAIL stock_reject got srej=%b cr=%0d vv=%b exp 1/3/0", sel_reject, credit, vend_valid); end
        tick();
        checks++; if (sel_reject !== 1'b0) begin failures++; $display("FAIL stock_pulse got=%b exp=0", sel_reject); end
        cancel = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if ({change_valid, change_coin, credit} !== {1'b1, C2, 8'd3}) begin
                failures++; $display("FAIL refund_stall2_%0d got cv=%b coin=%0d cr=%0d exp 1/1/3", k, change_valid, change_coin, credit); end
            change_ready = (k == 2);
            tick();
        end
        change_ready = 0;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({change_valid, change_coin, credit} !== {1'b1, C1, 8'd1}) begin
                failures++; $display("FAIL refund_stall1_%0d got cv=%b coin=%0d cr=%0d exp 1/0/1", k, change_valid, change_coin, credit); end
            change_ready = (k == 2);
            tick();
        end
        change_ready = 0;
        checks++; if ({change_valid, busy, credit} !== 10'd0) begin
            failures++; $display("FAIL refund_done got cv=%b busy=%b cr=%0d exp 0/0/0", change_valid, busy, credit); end
        // Affordable but sold out, then restocked.
        coin(C5);
        stock_empty = 4'b0001; sel_valid = 1; sel = 2'd0;
        tick();
        checks++; if ({sel_reject, credit} !== {1'b1, 8'd5}) begin
            failures++; $display("FAIL soldout_reject got srej=%b cr=%0d exp 1/5", sel_reject, credit); end
        stock_empty = 4'b0000; sel_valid = 1; sel = 2'd0; vend_ready = 1;
        tick();
        checks++; if ({sel_reject, vend_valid, vend_id, credit} !== {1'b0, 1'b1, 2'd0, 8'd0}) begin
            failures++; $display("FAIL restock_vend got srej=%b vv=%b id=%0d cr=%0d exp 0/1/0/0", sel_reject, vend_valid, vend_id, credit); end
        tick();
        vend_ready = 0;
    endtask

    task automatic test_max_credit();
        int n;
        do_reset();
        for (int k = 0; k < 9; k++) coin(C5);
        coin(C2); coin(C1);
        checks++; if (credit !== 8'd48) begin failures++; $display("FAIL max_build got=%0d exp=48", credit); end
        coin(C5);
        checks++; if ({coin_reject, credit} !== {1'b1, 8'd48}) begin
            failures++; $display("FAIL max_overflow got rej=%b cr=%0d exp 1/48", coin_reject, credit); end
        coin(CB);
        checks++; if ({coin_reject, credit} !== {1'b1, 8'd48}) begin
            failures++; $display("FAIL max_bad got rej=%b cr=%0d exp 1/48", coin_reject, credit); end
        coin(C2);
        checks++; if ({coin_reject, credit} !== {1'b0, 8'd50}) begin
            failures++; $display("FAIL max_fill got rej=%b cr=%0d exp 0/50", coin_reject, credit); end
        cancel = 1;
        tick();
        change_ready = 1;
        n = 0;
        for (int k = 0; k < 40 && change_valid === 1'b1; k++) begin
            checks++; if (change_coin !== C5) begin failures++; $display("FAIL max_refund_coin%0d got=%0d exp=2", k, change_coin); end
            n++;
            tick();
        end
        change_ready = 0;
        checks++; if ({n == 10, change_valid, credit} !== {1'b1, 1'b0, 8'd0}) begin
            failures++; $display("FAIL max_refund_total got coins=%0d cv=%b cr=%0d exp 10/0/0", n, change_valid, credit); end
    endtask

    task automatic test_priority();
        do_reset();
        coin(C5); coin(C5);
        coin_valid = 1; coin_type = C5; sel_valid = 1; sel = 2'd2; vend_ready = 1;
        tick();
        checks++; if ({coin_reject, vend_valid, vend_id, credit} !== {1'b1, 1'b1, 2'd2, 8'd0}) begin
            failures++; $display("FAIL prio_sel_over_coin got rej=%b vv=%b id=%0d cr=%0d exp 1/1/2/0", coin_reject, vend_valid, vend_id, credit); end
        tick();
        coin(C5); coin(C5);
        sel_valid = 1; sel = 2'd1;
        tick();
        tick();
        vend_ready = 0;
        coin_valid = 1; coin_type = C5; sel_valid = 1; sel = 2'd0; cancel = 1;
        tick();
        checks++; if ({coin_reject, sel_reject, change_valid, busy, credit} !== {4'b1111, 8'd3}) begin
            failures++; $display("FAIL busy_strobes got rej=%b srej=%b cv=%b busy=%b cr=%0d exp 1/1/1/1/3", coin_reject, sel_reject, change_valid, busy, credit); end
        change_ready = 1;
        tick(); tick();
        change_ready = 0;
        checks++; if ({change_valid, busy, credit} !== 10'd0) begin
            failures++; $display("FAIL busy_drain got cv=%b busy=%b cr=%0d exp 0/0/0", change_valid, busy, credit); end
    endtask

    task automatic test_reset_in_change();
        do_reset();
        coin(C5); coin(C1);
        cancel = 1;
        tick();
        checks++; if ({change_valid, change_coin, credit} !== {1'b1, C5, 8'd6}) begin
            failures++; $display("FAIL rstchg_pre got cv=%b coin=%0d cr=%0d exp 1/2/6", change_valid, change_coin, credit); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if ({credit, change_valid, busy} !== 10'd0) begin
            failures++; $display("FAIL rstchg_clear got cr=%0d cv=%b busy=%b exp 0/0/0", credit, change_valid, busy); end
        tick();
        checks++; if ({credit, change_valid, busy} !== 10'd0) begin
            failures++; $display("FAIL rstchg_after got cr=%0d cv=%b busy=%b exp 0/0/0", credit, change_valid, busy); end
    endtask

    task automatic test_random();
        logic [16:0] exp_v, got_v;
        int shown = 0;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 499) == 0);
            coin_valid   = ($urandom_range(0, 2) == 0);
            coin_type    = 2'($urandom);
            sel_valid    = ($urandom_range(0, 5) == 0);
            sel          = 2'($urandom);
            cancel       = ($urandom_range(0, 14) == 0);
            stock_empty  = 4'($urandom) & 4'($urandom);
            vend_ready   = $urandom_range(0, 1) == 1;
            change_ready = $urandom_range(0, 1) == 1;
            tick();
            rst = 0;
            exp_v = {8'(m_credit), m_vv, 2'(m_vid), m_cv, 2'(m_coin), m_crej, m_srej, (m_mode >= 2)};
            got_v = {credit, vend_valid, vend_id, change_valid, change_coin, coin_reject, sel_reject, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d got=%h exp=%h (credit,vv,id,cv,coin,crej,srej,busy)", k, got_v, exp_v);
                end
            end
        end
        vend_ready = 0; change_ready = 0;
    endtask

    initial begin
        rst = 1; coin_valid = 0; coin_type = 0; sel_valid = 0; sel = 0; cancel = 0;
        stock_empty = 0; vend_ready = 0; change_ready = 0;
        test_reset();
        test_exact_vend();
        test_vend_with_change();
        test_stock_and_cancel();
        test_max_credit();
        test_priority();
        test_reset_in_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
